pdm_decimator: RTL
==================

# pdm_decimator

Front-end audio capture stage for the recorder. Generates the microphone PDM clock and samples the 1-bit PDM stream. Low-pass/decimates each window of PDM bits into one signed 16-bit PCM sample, and hands it over on a valid/ready handshake to the sample path that writes record RAM. Runs in the system clock domain and replaces nothing downstream: its output feeds the same 16-bit sample bus the controller and address counter already consume.

## Interface
- `CLK_DIV`, 50 — system clocks per PDM clock half-period (100 MHz → 1 MHz pdm_clk); legal 2..255
- `DECIM`, 128 — PDM bits per PCM sample; power of two, 16..1024
- `clock`  in  1  system clock, 100 MHz, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `en`  in  1  capture enable (from controller)
- `pdm_data_i`  in  1  microphone PDM data
- `pdm_clk_o`  out  1  microphone clock
- `pdm_lrsel_o`  out  1  channel select, constant 0
- `pcm_data_o`  out  16  signed PCM sample
- `pcm_valid_o`  out  1  sample available
- `pcm_ready_i`  in  1  consumer accepts sample
- `overrun_o`  out  1  sticky: a sample was overwritten before acceptance
- `clr_overrun_i`  in  1  clears overrun_o

## Operation
- Divider: `div_cnt` counts 0..CLK_DIV-1 while en=1. At CLK_DIV-1 it wraps to 0 and toggles `pdm_clk_o`.
- Sampling: a PDM bit is taken on the clock edge where `pdm_clk_o` goes 0→1, using `pdm_data_i` as registered on that same edge.
- Window: `ones` counter (log2(DECIM)+1 bits) adds each sampled bit, and `bit_cnt` counts samples.
  - On the DECIM-th bit, compute `x = (ones_final - DECIM/2) <<< (16 - log2(DECIM))` in 17-bit signed. The final bit is included in `ones_final`.
  - Saturate x to [-32768, 32767]; only +32768 can overflow.
  - The ones and bit counters clear in the same cycle. No PDM bits are lost between windows.
- Output register: the new sample loads `pcm_data_o` and sets `pcm_valid_o`.
- Handshake: transfer occurs on a clock with pcm_valid_o=1 and pcm_ready_i=1; valid clears the next cycle unless a new sample loads in that same cycle. In that case valid stays 1 with the new data.
- Overrun: a new sample arriving while valid=1 and ready=0 overwrites data, keeps valid=1, and sets `overrun_o`.
  - `overrun_o` holds until `clr_overrun_i`=1.
  - If clear and a new overrun occur in the same cycle, set wins.
- en=0:
  - `pdm_clk_o` is forced to 0, and div_cnt, ones and bit_cnt clear.
  - `pcm_valid_o` clears and `pcm_data_o` holds. overrun_o is unaffected.
  - On re-enable, a full DECIM-bit window is needed before the first sample.

## Timing
- Reset values: pdm_clk_o=0, pdm_lrsel_o=0, pcm_data_o=0x0000, pcm_valid_o=0, overrun_o=0, all counters 0.
- pdm_clk period: 2·CLK_DIV clocks. The first rising edge comes 2·CLK_DIV-1 clocks... precisely at the 2nd divider wrap after en rises.
- PCM rate: one sample per 2·CLK_DIV·DECIM clocks (12800 at defaults, 7.8125 kHz).
- Latency: pcm_valid_o rises 1 clock after the edge sampling the DECIM-th bit (registered output).
- Reset mid-window: all state is cleared immediately (async). The window in progress is discarded and no partial sample is emitted.
- pcm_ready_i may be held high permanently; the sample is then consumed 1 cycle after valid rises.

## Configuration
- `PDM_DECIM_DC_BLOCK_EN` defined: a one-pole DC-blocking high-pass sits between saturation and the output register.
  - `avg` is 24-bit signed Q16.8, reset 0.
  - Output: `y = sat16(x - avg[23:8])`.
  - Update: `avg <= avg + (((x <<< 8) - avg) >>> 8)`, evaluated on each new sample.
  - Adds no extra latency; the output remains registered.
- Undefined: `pcm_data_o` = saturated x directly, and no avg register exists.

## Test plan
- Defaults; en=1; pdm_data_i=1 constantly; ready=1.
  - → First valid at clock ≈ 12800+CLK_DIV, pcm_data_o=0x7FFF.
  - → Subsequent valids exactly 12800 clocks apart.
- pdm_data_i=0 constantly → pcm_data_o=0x8000 each sample.
- pdm_data_i toggled every pdm_clk rising edge (1,0,1,0…) → pcm_data_o=0x0000; pdm_clk_o measured at 100-clock period, 50% duty.
- ready=0 across two windows, constant 1 input.
  - → overrun_o=1 after the second sample, valid stays 1, data=0x7FFF.
  - → Pulse clr_overrun_i → overrun_o=0.
- Assert reset=0 for 3 clocks at bit 60 of a window → all outputs at reset values; next valid a full window (12800 clocks) after the first new pdm_clk edge.
- With `PDM_DECIM_DC_BLOCK_EN`, constant 1 input.
  - → First sample 0x7FFF.
  - → |pcm_data_o| < 64 after 2048 samples.
  - → Without the macro, all samples stay 0x7FFF.

Source files
------------

// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM microphone clock generator and boxcar decimator producing signed 16-bit PCM
// on a valid/ready port. Define PDM_DECIM_DC_BLOCK_EN to insert a one-pole DC-blocking high-pass.
module pdm_decimator #(
  parameter int CLK_DIV = 50,
  parameter int DECIM   = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        pdm_data_i,
  output logic        pdm_clk_o,
  output logic        pdm_lrsel_o,
  output logic [15:0] pcm_data_o,
  output logic        pcm_valid_o,
  input  logic        pcm_ready_i,
  output logic        overrun_o,
  input  logic        clr_overrun_i
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LOG2D = $clog2(DECIM);
  localparam int SHIFT = 16 - LOG2D;

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               pclk_q, pclk_d;
  logic               primed_q, primed_d;
  logic [LOG2D:0]     ones_q, ones_d;
  logic [LOG2D-1:0]   bit_cnt_q, bit_cnt_d;
  logic [15:0]        pcm_q, pcm_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  logic               wrap, rise, last_bit;
  logic [LOG2D:0]     ones_fin;
  logic signed [16:0] x_raw;
  logic [15:0]        x_sat, smp;

`ifdef PDM_DECIM_DC_BLOCK_EN
  logic [23:0]        avg_q, avg_d;
  logic [16:0]        y_raw;
  logic [24:0]        avg_diff;
`endif

  always_comb begin
    wrap     = en && (div_cnt_q == DIV_W'(CLK_DIV - 1));
    rise     = wrap && primed_q && !pclk_q;
    last_bit = rise && (bit_cnt_q == LOG2D'(DECIM - 1));
    ones_fin = ones_q + {{LOG2D{1'b0}}, pdm_data_i};
    x_raw    = (17'(ones_fin) - 17'(DECIM / 2)) <<< SHIFT;

    x_sat = x_raw[15:0];
    if (!x_raw[16] && x_raw[15]) x_sat = 16'h7FFF;
    else if (x_raw[16] && !x_raw[15]) x_sat = 16'h8000;

`ifdef PDM_DECIM_DC_BLOCK_EN
    y_raw = {x_sat[15], x_sat} - {avg_q[23], avg_q[23:8]};
    smp   = y_raw[15:0];
    if (!y_raw[16] && y_raw[15]) smp = 16'h7FFF;
    else if (y_raw[16] && !y_raw[15]) smp = 16'h8000;
    // avg += ((x<<8) - avg) >>> 8, with the shifted difference sign-extended back to 24 bits
    avg_diff = {x_sat[15], x_sat, 8'h00} - {avg_q[23], avg_q};
    avg_d    = avg_q;
    if (last_bit) avg_d = avg_q + {{7{avg_diff[24]}}, avg_diff[24:8]};
`else
    smp = x_sat;
`endif

    div_cnt_d = div_cnt_q;
    pclk_d    = pclk_q;
    primed_d  = primed_q;
    ones_d    = ones_q;
    bit_cnt_d = bit_cnt_q;
    pcm_d     = pcm_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;

    if (!en) begin
      div_cnt_d = '0;
      pclk_d    = 1'b0;
      primed_d  = 1'b0;
      ones_d    = '0;
      bit_cnt_d = '0;
      valid_d   = 1'b0;
    end else begin
      // The first wrap after enable only arms the divider, so the first rising edge lands on the 2nd wrap.
      if (wrap) begin
        div_cnt_d = '0;
        if (primed_q) pclk_d = !pclk_q;
        else primed_d = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
      if (valid_q && pcm_ready_i) valid_d = 1'b0;
      if (rise) begin
        if (last_bit) begin
          ones_d    = '0;
          bit_cnt_d = '0;
          pcm_d     = smp;
          valid_d   = 1'b1;
        end else begin
          ones_d    = ones_fin;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end

    if (last_bit && valid_q && !pcm_ready_i) ovr_d = 1'b1;
    else if (clr_overrun_i) ovr_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      pclk_q    <= 1'b0;
      primed_q  <= 1'b0;
      ones_q    <= '0;
      bit_cnt_q <= '0;
      pcm_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef PDM_DECIM_DC_BLOCK_EN
      avg_q     <= '0;
`endif
    end else begin
      div_cnt_q <= div_cnt_d;
      pclk_q    <= pclk_d;
      primed_q  <= primed_d;
      ones_q    <= ones_d;
      bit_cnt_q <= bit_cnt_d;
      pcm_q     <= pcm_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
`ifdef PDM_DECIM_DC_BLOCK_EN
      avg_q     <= avg_d;
`endif
    end
  end

  assign pdm_clk_o   = pclk_q;
  assign pdm_lrsel_o = 1'b0;
  assign pcm_data_o  = pcm_q;
  assign pcm_valid_o = valid_q;
  assign overrun_o   = ovr_q;

endmodule
